// File: rtl/accreg_pkg.sv
// Shared definitions for the accumulator register file: opcode encoding and
// default sizing constants.
package accreg_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_CPYIN  = 3'd1,
    OP_CPYOUT = 3'd2,
    OP_ALU_WR = 3'd3,
    OP_SWAP   = 3'd4,
    OP_PUSH   = 3'd5,
    OP_POP    = 3'd6,
    OP_CLR    = 3'd7
  } accreg_op_t;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_NREGS       = 8;
  localparam int DEF_STACK_DEPTH = 4;

endpackage

// File: rtl/accum_reg_file_if.sv
// Decoder/ALU-facing bundle of the accumulator register file. No handshake:
// one opcode is accepted every cycle, results appear the cycle after.
interface accum_reg_file_if
  import accreg_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NREGS       = DEF_NREGS,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  localparam int SEL_W      = $clog2(NREGS),
  localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
);
  accreg_op_t       op;
  logic [SEL_W-1:0] reg_sel;
  logic [WIDTH-1:0] write_data;
  logic             flag_we;
  logic             flag_in;
  logic             err_clr;
  logic [WIDTH-1:0] res_val;
  logic [WIDTH-1:0] reg_val;
  logic             flag;
  logic [CNT_W-1:0] stk_count;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;

  modport master (
    output op, reg_sel, write_data, flag_we, flag_in, err_clr,
    input  res_val, reg_val, flag, stk_count, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  op, reg_sel, write_data, flag_we, flag_in, err_clr,
    output res_val, reg_val, flag, stk_count, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/accreg_stack.sv
// Accumulator LIFO: guarded push/pop with occupancy count and a sticky
// overflow/underflow error (a new error wins over a same-cycle clear).
module accreg_stack #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4,
  localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err
);
  logic [WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [WIDTH-1:0] mem_d [STACK_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(STACK_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    top_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (count_q == CNT_W'(i + 1)) top_data = mem_q[i];
    end
  end

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (push_ok && count_q == CNT_W'(i)) mem_d[i] = push_data;
    end
    if (push_ok)     count_d = count_q + 1'b1;
    else if (pop_ok) count_d = count_q - 1'b1;
    if ((push && full) || (pop && empty)) err_d = 1'b1;
    else if (err_clr)                     err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign count = count_q;
  assign err   = err_q;
endmodule

// File: rtl/accum_reg_file.sv
// Accumulator-style register file: NREGS general registers, accumulator, compare
// flag and accumulator LIFO. Define ACCREG_ZERO_REG_EN to hardwire register 0 to zero.
module accum_reg_file
  import accreg_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NREGS       = DEF_NREGS,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  localparam int SEL_W      = $clog2(NREGS),
  localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  accum_reg_file_if.slave  bus
);
`ifdef ACCREG_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] res_q, res_d;
  logic             flag_q, flag_d;
  logic             reg_we;
  logic [WIDTH-1:0] stk_top;
  logic             stk_empty;

  // Out-of-range selects read as zero and never write.
  always_comb begin
    rd_val = '0;
    if (int'(bus.reg_sel) < NREGS) rd_val = regs_q[bus.reg_sel];
  end

  assign reg_we = (bus.op == OP_CPYOUT) || (bus.op == OP_SWAP);

  for (genvar i = 0; i < NREGS; i++) begin : g_regs
    if (ZERO_REG && i == 0) begin : g_zero
      assign regs_q[i] = '0;
    end else begin : g_store
      logic [WIDTH-1:0] r_q, r_d;
      always_comb begin
        r_d = r_q;
        if (reg_we && bus.reg_sel == SEL_W'(i)) r_d = res_q;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '0;
        else        r_q <= r_d;
      end
      assign regs_q[i] = r_q;
    end
  end

  always_comb begin
    res_d = res_q;
    case (bus.op)
      OP_CPYIN, OP_SWAP: res_d = rd_val;
      OP_ALU_WR:         res_d = bus.write_data;
      OP_POP:            if (!stk_empty) res_d = stk_top;
      OP_CLR:            res_d = '0;
      default:           res_d = res_q;
    endcase
    flag_d = bus.flag_we ? bus.flag_in : flag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      flag_q <= flag_d;
    end
  end

  accreg_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.op == OP_PUSH),
    .pop       (bus.op == OP_POP),
    .err_clr   (bus.err_clr),
    .push_data (res_q),
    .top_data  (stk_top),
    .count     (bus.stk_count),
    .full      (bus.stk_full),
    .empty     (stk_empty),
    .err       (bus.stk_err)
  );

  assign bus.stk_empty = stk_empty;
  assign bus.res_val   = res_q;
  assign bus.reg_val   = rd_val;
  assign bus.flag      = flag_q;
endmodule

// File: doc/accum_reg_file.md
# accum_reg_file

Parametrised accumulator-style register file for the datapath: NREGS general registers plus one accumulator (`res`) that receives ALU results. One opcode per cycle selects copy-in, copy-out, ALU write, swap, accumulator push/pop onto a small LIFO, or accumulator clear. It also holds the compare flag produced by the ALU. It sits between the decoder, which drives `op` and `reg_sel`, and the ALU, which consumes `res_val`/`reg_val` and returns `write_data`.

## Interface
Parameters:
- WIDTH, 16, data width of registers, accumulator and stack entries
- NREGS, 8, number of general registers (≥2)
- STACK_DEPTH, 4, accumulator LIFO entries (≥1)
- SEL_W, $clog2(NREGS), register-select width (derived)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  3  operation: 0 NOP, 1 CPYIN, 2 CPYOUT, 3 ALU_WR, 4 SWAP, 5 PUSH, 6 POP, 7 CLR
- reg_sel  in  SEL_W  general-register select
- write_data  in  WIDTH  ALU result, used by ALU_WR
- flag_we  in  1  load compare flag this cycle
- flag_in  in  1  compare result from ALU
- err_clr  in  1  clear sticky stack error
- res_val  out  WIDTH  accumulator value (register output)
- reg_val  out  WIDTH  combinational read of register `reg_sel`
- flag  out  1  compare flag
- stk_count  out  $clog2(STACK_DEPTH+1)  occupied LIFO entries
- stk_full / stk_empty  out  1 each  LIFO status, derived from stk_count
- stk_err  out  1  sticky overflow/underflow indication

## Operation
- CPYIN: res ← reg[reg_sel].
- CPYOUT: reg[reg_sel] ← res.
- ALU_WR: res ← write_data.
- SWAP: res ← reg[reg_sel] and reg[reg_sel] ← res, both using pre-edge values.
- PUSH: stack[count] ← res; count+1; res unchanged. If full, nothing changes and stk_err is set.
- POP: res ← stack[count-1]; count-1. If empty, nothing changes and stk_err is set.
- CLR: res ← 0. Registers, stack and flag are unchanged.
- NOP: no state change.
- reg_sel ≥ NREGS (non-power-of-two NREGS): reads return 0; register writes are discarded; SWAP still loads 0 into res.
- Flag: independent of op. flag ← flag_in when flag_we is high, otherwise it holds.
- stk_err: if set and err_clr occur in the same cycle, set wins.
- No stack pointer wrap-around. Full and empty are guarded as described above.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): all registers, res, stack entries, flag, stk_err and stk_count go to 0. Therefore stk_empty=1 and stk_full=0.
- reg_val: zero latency. It is a combinational mux of the current reg_sel over pre-edge register contents, with no write-through.
- All writes land at the rising edge. A result is visible on res_val or reg_val the cycle after the op.
- Back-to-back ops are allowed every cycle. PUSH then POP returns the pushed value in 2 cycles.
- Reset asserted mid-sequence abandons all state immediately. The stack is empty after release.

## Configuration
- ACCREG_ZERO_REG_EN defined: register 0 is hardwired to zero.
  - Reads of reg 0 return 0.
  - CPYOUT to reg 0 is discarded.
  - SWAP with reg 0 sets res←0 and discards the register-side write.
  - No storage is inferred for reg 0.
- Undefined: register 0 is an ordinary register.

## Structure
- Package `accreg_pkg`:
  - op encoding enum typedef `accreg_op_t` with the eight values above
  - default parameter constants
- Sub-module `accreg_stack`: parametrised LIFO (WIDTH, STACK_DEPTH) with push/pop/count/full/empty and the sticky error logic.
- The register array, accumulator and flag remain in the top module.

## Test plan
- Reset: assert rst_n=0 mid-run → res_val=0, reg_val=0 for every sel, flag=0, stk_count=0, stk_empty=1, stk_err=0.
- ALU_WR 16'h1234, then CPYOUT sel=3, then CLR, then CPYIN sel=3 → reg_val(sel 3)=16'h1234; res_val=0 after CLR; res_val=16'h1234 after CPYIN.
- Swap: reg5=16'h00AA and res=16'h5500, then SWAP sel=5 → next cycle res_val=16'h00AA and reg_val(sel 5)=16'h5500.
- Stack fill and overflow, STACK_DEPTH=4: push 1,2,3,4 via ALU_WR/PUSH pairs → stk_full=1. A fifth PUSH → stk_err=1, count stays 4. POP ×4 → res sequence 4,3,2,1, then stk_empty=1.
- Underflow precedence: POP on empty with err_clr=1 in the same cycle → stk_err=1 and res unchanged. err_clr alone next cycle → stk_err=0.
- With ACCREG_ZERO_REG_EN: res=16'hFFFF, CPYOUT sel=0 → reg_val(sel 0)=0. SWAP sel=0 → res_val=0. Without the macro, the same sequence → reg_val(sel 0)=16'hFFFF.
